// File: rtl/wb_stream_master.sv
// Single-access Wishbone classic initiator: one val/rdy request becomes one bus cycle and one val/rdy response; 2-cycle min accept-to-response.
// Response is held until resp_rdy and no request is taken meanwhile. Defining WB_MASTER_TIMEOUT_EN adds an ack timeout that answers with err=1.
module wb_stream_master #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255,
   localparam int SEL_W      = DATA_W / 8,
   localparam int REQ_W      = 1 + SEL_W + DATA_W + ADDR_W
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic              req_val,
   output logic              req_rdy,
   input  logic [REQ_W-1:0]  req_msg,
   output logic              resp_val,
   input  logic              resp_rdy,
   output logic [DATA_W:0]   resp_msg,
   output logic              wbm_cyc_o,
   output logic              wbm_stb_o,
   output logic              wbm_we_o,
   output logic [SEL_W-1:0]  wbm_sel_o,
   output logic [ADDR_W-1:0] wbm_adr_o,
   output logic [DATA_W-1:0] wbm_dat_o,
   input  logic              wbm_ack_i,
   input  logic [DATA_W-1:0] wbm_dat_i
);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_e;

   state_e              state_q, state_d;
   logic                cyc_q, cyc_d;
   logic                we_q, we_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [ADDR_W-1:0]   adr_q, adr_d;
   logic [DATA_W-1:0]   dat_q, dat_d;
   logic                resp_val_q, resp_val_d;
   logic [DATA_W-1:0]   resp_dat_q, resp_dat_d;

`ifdef WB_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             resp_err_q, resp_err_d;
   logic             timeout_hit;
   // The edge at which the count would reach TIMEOUT_CYC is the abort edge.
   assign timeout_hit = (cnt_q == CNT_LAST);
`else
   logic timeout_unused;
   assign timeout_unused = (TIMEOUT_CYC >= 1);
`endif

   always_comb begin
      state_d    = state_q;
      cyc_d      = cyc_q;
      we_d       = we_q;
      sel_d      = sel_q;
      adr_d      = adr_q;
      dat_d      = dat_q;
      resp_val_d = resp_val_q;
      resp_dat_d = resp_dat_q;
`ifdef WB_MASTER_TIMEOUT_EN
      cnt_d      = cnt_q;
      resp_err_d = resp_err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_val) begin
               we_d    = req_msg[REQ_W-1];
               sel_d   = req_msg[REQ_W-2 -: SEL_W];
               dat_d   = req_msg[ADDR_W +: DATA_W];
               adr_d   = req_msg[ADDR_W-1:0];
               cyc_d   = 1'b1;
               state_d = S_BUS;
            end
         end
         S_BUS: begin
            if (wbm_ack_i) begin
               cyc_d      = 1'b0;
               resp_val_d = 1'b1;
               resp_dat_d = we_q ? '0 : wbm_dat_i;
               state_d    = S_RESP;
`ifdef WB_MASTER_TIMEOUT_EN
               cnt_d      = '0;
               resp_err_d = 1'b0;
            end else if (timeout_hit) begin
               cyc_d      = 1'b0;
               resp_val_d = 1'b1;
               resp_dat_d = '0;
               resp_err_d = 1'b1;
               cnt_d      = '0;
               state_d    = S_RESP;
            end else begin
               cnt_d      = cnt_q + CNT_W'(1);
`endif
            end
         end
         S_RESP: begin
            if (resp_rdy) begin
               resp_val_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q    <= S_IDLE;
         cyc_q      <= 1'b0;
         we_q       <= 1'b0;
         sel_q      <= '0;
         adr_q      <= '0;
         dat_q      <= '0;
         resp_val_q <= 1'b0;
         resp_dat_q <= '0;
      end else begin
         state_q    <= state_d;
         cyc_q      <= cyc_d;
         we_q       <= we_d;
         sel_q      <= sel_d;
         adr_q      <= adr_d;
         dat_q      <= dat_d;
         resp_val_q <= resp_val_d;
         resp_dat_q <= resp_dat_d;
      end
   end

`ifdef WB_MASTER_TIMEOUT_EN
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         cnt_q      <= '0;
         resp_err_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         resp_err_q <= resp_err_d;
      end
   end
   assign resp_msg = {resp_err_q, resp_dat_q};
`else
   assign resp_msg = {1'b0, resp_dat_q};
`endif

   // Held low through reset so upstream cannot hand over a message that would be lost.
   assign req_rdy   = wb_rst_ni && (state_q == S_IDLE);
   assign resp_val  = resp_val_q;
   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = cyc_q;
   assign wbm_we_o  = we_q;
   assign wbm_sel_o = sel_q;
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_stream_master.sv
// Randomized scoreboard bench for wb_stream_master; define WB_MASTER_TIMEOUT_EN for both files to exercise the timeout build.
module tb_wb_stream_master;
   localparam int TC = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_val = 1'b0;
   logic        req_rdy;
   logic [68:0] req_msg = '0;
   logic        resp_val;
   logic        resp_rdy = 1'b0;
   logic [32:0] resp_msg;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat_o;
   logic        ack = 1'b0;
   logic [31:0] dat_i = '0;

   int errors = 0;
   int checks = 0;
   int rdy_mode = 2;
   int last_cyc_len = 0;

   logic [32:0] exp_q[$];
   logic [68:0] bus_q[$];
   int          wait_q[$];
   logic [31:0] ref_mem[16];
   logic [31:0] slv_mem[16];

   always #5 clk = ~clk;

   wb_stream_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TC)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
      .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
      .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
      .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_ack_i(ack), .wbm_dat_i(dat_i)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic fail_event(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got unexpected event, required none", name);
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // Issue one request; expected response comes from the reference memory and the ack-delay rule.
   task automatic send(input logic w, input logic [3:0] s, input logic [31:0] d,
                       input logic [31:0] a, input int waits);
      int  n;
      bit  tmo;
      n = 0;
      req_val = 1'b1;
      req_msg = {w, s, d, a};
      while (!req_rdy && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("req_accept", req_rdy, 1'b1);
      if (!req_rdy) begin
         req_val = 1'b0;
         return;
      end
      tmo = (waits < 0);
`ifdef WB_MASTER_TIMEOUT_EN
      tmo = tmo || (waits >= TC);
      if (tmo) exp_q.push_back({1'b1, 32'h0});
`endif
      if (!tmo) begin
         if (w) begin
            ref_mem[a[5:2]] = merge(ref_mem[a[5:2]], d, s);
            exp_q.push_back(33'h0);
         end else begin
            exp_q.push_back({1'b0, ref_mem[a[5:2]]});
         end
      end
      bus_q.push_back({w, s, d, a});
      wait_q.push_back(waits);
      @(negedge clk);
      req_val = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !req_rdy) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain", (exp_q.size() == 0) && req_rdy, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_cyc", cyc, 1'b0);
      chk("rst_async_stb", stb, 1'b0);
      chk("rst_async_resp_val", resp_val, 1'b0);
      exp_q.delete();
      bus_q.delete();
      wait_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_release_req_rdy", req_rdy, 1'b1);
      chk("rst_release_resp_val", resp_val, 1'b0);
   endtask

   // Wishbone slave: acks after the requested number of wait states, applies writes to its memory.
   initial begin : slave
      int          wt, cnt;
      bit          busy;
      logic [68:0] expb;
      wt = 0; cnt = 0; busy = 0; expb = '0;
      forever begin
         @(negedge clk);
         if (!rst_n || !cyc) begin
            if (busy) last_cyc_len = cnt;
            busy  = 0;
            cnt   = 0;
            ack   = rst_n ? 1'($urandom_range(0, 1)) : 1'b0;
            dat_i = $urandom;
         end else begin
            if (!busy) begin
               busy = 1;
               if (bus_q.size() == 0) begin
                  fail_event("bus_spurious_cycle");
                  expb = {we, sel, dat_o, adr};
                  wt   = 0;
               end else begin
                  expb = bus_q.pop_front();
                  wt   = wait_q.pop_front();
               end
            end
            chk("bus_req", {stb, we, sel, dat_o, adr}, {1'b1, expb});
            cnt++;
            if (wt >= 0 && cnt - 1 == wt) begin
               ack = 1'b1;
               if (we) begin
                  slv_mem[adr[5:2]] = merge(slv_mem[adr[5:2]], dat_o, sel);
                  dat_i = $urandom;
               end else begin
                  dat_i = slv_mem[adr[5:2]];
               end
            end else begin
               ack   = 1'b0;
               dat_i = $urandom;
            end
         end
      end
   end

   initial begin : rdy_drv
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       resp_rdy = ($urandom_range(0, 3) != 0);
            1:       resp_rdy = 1'b0;
            default: resp_rdy = 1'b1;
         endcase
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rst_n && resp_val && resp_rdy) begin
            if (exp_q.size() == 0) fail_event("resp_spurious");
            else chk("resp_msg", resp_msg, exp_q.pop_front());
         end
      end
   end

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: got no end of test, required end before time limit");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin : stim
      bit          ok;
      int          n;
      logic        w;
      logic [3:0]  s;
      logic [31:0] d, a;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = 32'hC0DE_0000 + 32'(i) * 32'h0101_0101;
         slv_mem[i] = 32'hC0DE_0000 + 32'(i) * 32'h0101_0101;
      end
      ref_mem[1] = 32'hDEAD_BEEF;
      slv_mem[1] = 32'hDEAD_BEEF;

      #12;
      chk("reset_bus", {cyc, stb, we, sel, adr, dat_o}, '0);
      chk("reset_resp", {resp_val, resp_msg}, '0);
      chk("reset_req_rdy", req_rdy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_req_rdy", req_rdy, 1'b1);

      // Write, acked in the first bus cycle: response two cycles after accept.
      send(1'b1, 4'hF, 32'h0000_00AB, 32'h3000_0000, 0);
      chk("t1_cyc_high", {cyc, stb}, 2'b11);
      @(negedge clk);
      chk("t1_resp_val", resp_val, 1'b1);
      chk("t1_resp_msg", resp_msg, 33'h0);
      chk("t1_cyc_low", cyc, 1'b0);
      wait_idle();
      chk("t1_cyc_len", last_cyc_len, 1);

      // Read with three wait states.
      send(1'b0, 4'hF, 32'h0, 32'h3000_0004, 3);
      wait_idle();
      chk("t2_cyc_len", last_cyc_len, 4);

      // Response backpressure with a queued request.
      rdy_mode = 1;
      repeat (2) @(negedge clk);
      send(1'b0, 4'h3, 32'h1234_5678, 32'h3000_0008, 1);
      n = 0;
      while (!resp_val && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t3_resp_seen", resp_val, 1'b1);
      req_val = 1'b1;
      req_msg = {1'b1, 4'hF, 32'h5555_AAAA, 32'h3000_000C};
      repeat (5) begin
         @(negedge clk);
         chk("t3_hold_val", resp_val, 1'b1);
         chk("t3_hold_msg", resp_msg, {1'b0, ref_mem[2]});
         chk("t3_req_blocked", {req_rdy, cyc}, 2'b00);
      end
      rdy_mode = 2;
      send(1'b1, 4'hF, 32'h5555_AAAA, 32'h3000_000C, 2);
      wait_idle();

`ifdef WB_MASTER_TIMEOUT_EN
      send(1'b0, 4'hF, 32'h0, 32'h3000_0010, -1);
      wait_idle();
      chk("t4_timeout_len", last_cyc_len, TC);
`else
      send(1'b0, 4'hF, 32'h0, 32'h3000_0010, -1);
      ok = 1;
      repeat (100) begin
         @(negedge clk);
         if (!cyc || resp_val) ok = 0;
      end
      chk("t4_hang", ok, 1'b1);
      do_reset();
`endif

      // Ack on what would be the terminal-count cycle.
      send(1'b0, 4'hF, 32'h0, 32'h3000_0014, TC - 1);
      wait_idle();
      chk("t5_tie_len", last_cyc_len, TC);

      // Reset in the middle of a bus cycle, then a normal transaction.
      send(1'b0, 4'hF, 32'h0, 32'h3000_0018, 20);
      repeat (2) @(negedge clk);
      do_reset();
      repeat (3) @(negedge clk);
      send(1'b0, 4'hF, 32'h0, 32'h3000_001C, 1);
      wait_idle();

      rdy_mode = 0;
      repeat (150) begin
         w = 1'($urandom_range(0, 1));
         s = 4'($urandom);
         d = $urandom;
         a = 32'h3000_0000 | (32'($urandom_range(0, 15)) << 2);
         send(w, s, d, a, $urandom_range(0, 6));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle();
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
